// File: rtl/regscan_ctrl.sv
// -----------------------------------------------------------------------------
// regscan_ctrl
//
// Steps through the CPU temporaries/saved registers ($t0-$t7, $s0-$s7,
// $t8, $t9 = register numbers 8..25), captures the value returned by the
// register-file output mux for the selected register, and hands it to a
// display sink over a valid/ready channel. After every completed transfer the
// controller dwells in HOLD, where it either waits for a manual step or
// refresh (mode=0) or advances automatically (mode=1).
//
// Parameters
//   DWELL       cycles spent in HOLD before an automatic advance or refresh
//               (legal range 2 .. 2^26-1)
//
// Ports
//   clk         single clock, rising-edge
//   reset       synchronous, active-high
//   mode        0 = manual step, 1 = auto scan (sampled only in HOLD)
//   btn_next    single-cycle pulse, step to the next register
//   btn_prev    single-cycle pulse, step to the previous register
//   sel         register number driven to the register output mux
//   data_in     mux output for the current sel
//   disp_data   captured register value for the display sink
//   disp_valid  disp_data is valid
//   disp_ready  sink accepts disp_data
//   busy        high in every state except HOLD
//   dbg_state   current FSM state (SEL=0, LATCH=1, SEND=2, HOLD=3)
//
// Handshake (disp_valid / disp_ready): a transfer happens on a rising edge
// where disp_valid=1 and disp_ready=1. Once disp_valid is raised, disp_valid
// and disp_data stay constant until that edge; disp_valid never depends
// combinationally on disp_ready, and disp_ready may be high before
// disp_valid rises.
// -----------------------------------------------------------------------------
module regscan_ctrl #(
    parameter int unsigned DWELL = 50000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mode,
    input  logic        btn_next,
    input  logic        btn_prev,
    output logic [4:0]  sel,
    input  logic [31:0] data_in,
    output logic [31:0] disp_data,
    output logic        disp_valid,
    input  logic        disp_ready,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        ST_SEL   = 2'd0,
        ST_LATCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam logic [4:0]  SEL_FIRST  = 5'd8;
    localparam logic [4:0]  SEL_LAST   = 5'd25;
    localparam logic [25:0] DWELL_LAST = 26'(DWELL - 1);

    state_t      state_q;
    logic [4:0]  sel_q;
    logic [31:0] data_q;
    logic        valid_q;
    logic [25:0] cnt_q;

    // Neighbouring register numbers, wrapping inside 8..25.
    logic [4:0]  sel_next_d;
    logic [4:0]  sel_prev_d;
    logic        dwell_done;
    logic        step_next;
    logic        step_prev;

    always_comb begin
        sel_next_d = (sel_q == SEL_LAST)  ? SEL_FIRST : sel_q + 5'd1;
        sel_prev_d = (sel_q == SEL_FIRST) ? SEL_LAST  : sel_q - 5'd1;
        dwell_done = (cnt_q == DWELL_LAST);
        // Simultaneous pulses cancel; neither direction is taken.
        step_next  = btn_next & ~btn_prev;
        step_prev  = btn_prev & ~btn_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_SEL;
            sel_q   <= SEL_FIRST;
            data_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                // One settling cycle for the register output mux.
                ST_SEL: begin
                    state_q <= ST_LATCH;
                end

                ST_LATCH: begin
                    data_q  <= data_in;
                    valid_q <= 1'b1;
                    state_q <= ST_SEND;
                end

                // Buttons are not looked at here, so pulses are dropped.
                ST_SEND: begin
                    if (disp_ready) begin
                        valid_q <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= ST_HOLD;
                    end
                end

                // mode is only consulted here; switching it does not restart
                // the dwell count already in progress.
                ST_HOLD: begin
                    cnt_q <= cnt_q + 26'd1;
                    if (mode) begin
                        if (dwell_done) begin
                            sel_q   <= sel_next_d;
                            cnt_q   <= '0;
                            state_q <= ST_SEL;
                        end
                    end else if (step_next) begin
                        sel_q   <= sel_next_d;
                        cnt_q   <= '0;
                        state_q <= ST_SEL;
                    end else if (step_prev) begin
                        sel_q   <= sel_prev_d;
                        cnt_q   <= '0;
                        state_q <= ST_SEL;
                    end else if (dwell_done) begin
                        // Manual refresh: recapture the same register.
                        cnt_q   <= '0;
                        state_q <= ST_SEL;
                    end
                end

                default: begin
                    state_q <= ST_SEL;
                end
            endcase
        end
    end

    assign sel        = sel_q;
    assign disp_data  = data_q;
    assign disp_valid = valid_q;
    assign busy       = (state_q != ST_HOLD);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_regscan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_regscan_ctrl
//
// Directed sequence around a behavioural model of the register scanner: the
// register file is an array indexed by sel, the expected register number is
// computed with modulo arithmetic over 8..25, and each display transfer is
// compared against the expected register, its value and the number of idle
// (not busy) cycles that preceded it. DWELL is 4.
// -----------------------------------------------------------------------------
module tb_regscan_ctrl;

    localparam int unsigned DWELL = 4;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic        mode;
    logic        btn_next;
    logic        btn_prev;
    logic [4:0]  sel;
    logic [31:0] data_in;
    logic [31:0] disp_data;
    logic        disp_valid;
    logic        disp_ready;
    logic        busy;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    // Register file behind the output mux.
    logic [31:0] regfile [32];
    assign data_in = regfile[sel];

    regscan_ctrl #(.DWELL(DWELL)) dut (
        .clk        (clk),
        .reset      (reset),
        .mode       (mode),
        .btn_next   (btn_next),
        .btn_prev   (btn_prev),
        .sel        (sel),
        .data_in    (data_in),
        .disp_data  (disp_data),
        .disp_valid (disp_valid),
        .disp_ready (disp_ready),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // ---------------- reference model ----------------
    function automatic logic [4:0] model_next(input logic [4:0] s);
        int idx;
        idx = (int'(s) - 8 + 1) % 18;
        return 5'(idx + 8);
    endfunction

    function automatic logic [4:0] model_prev(input logic [4:0] s);
        int idx;
        idx = (int'(s) - 8 + 17) % 18;
        return 5'(idx + 8);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic n, input logic p);
        btn_next = n;
        btn_prev = p;
        tick;
        btn_next = 1'b0;
        btn_prev = 1'b0;
    endtask

    // Runs until one display transfer completes (bounded). Reports the
    // register shown, the value shown and the idle cycles seen before it.
    task automatic wait_capture(input bit rnd, output logic [4:0] s,
                                output logic [31:0] d, output int holds);
        bit got;
        got   = 1'b0;
        holds = 0;
        s     = '0;
        d     = '0;
        for (int i = 0; i < 100 && !got; i++) begin
            if (rnd) begin
                btn_next   = 1'($urandom_range(0, 1));
                btn_prev   = 1'($urandom_range(0, 1));
                disp_ready = 1'($urandom_range(0, 1));
            end
            if (disp_valid && disp_ready) begin
                s   = sel;
                d   = disp_data;
                got = 1'b1;
            end else if (!busy) begin
                holds++;
            end
            tick;
        end
        btn_next   = 1'b0;
        btn_prev   = 1'b0;
        disp_ready = 1'b1;
        chk("capture_seen", 32'(got), 32'd1);
    endtask

    // Manual step from HOLD, then the resulting capture.
    task automatic step_manual(input string tag, input logic n, input logic p,
                               input logic [4:0] exp_sel);
        logic [4:0]  s;
        logic [31:0] d;
        int          h;
        chk({tag, "_idle_before"}, 32'(busy), 32'd0);
        pulse(n, p);
        chk({tag, "_sel"}, 32'(sel), 32'(exp_sel));
        wait_capture(1'b0, s, d, h);
        chk({tag, "_cap_sel"}, 32'(s), 32'(exp_sel));
        chk({tag, "_cap_data"}, d, regfile[exp_sel]);
        chk({tag, "_cap_holds"}, 32'(h), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    logic [4:0]  exp_sel;
    logic [4:0]  cs;
    logic [31:0] cd;
    int          ch;
    logic [31:0] held;

    initial begin
        for (int i = 0; i < 32; i++) regfile[i] = $urandom;
        regfile[8] = 32'h1234_5678;

        // Reset state
        reset = 1'b1; mode = 1'b0; btn_next = 1'b0; btn_prev = 1'b0; disp_ready = 1'b1;
        tick; tick; tick;
        chk("rst_sel", 32'(sel), 32'd8);
        chk("rst_valid", 32'(disp_valid), 32'd0);
        chk("rst_data", disp_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);

        // First capture after release is register 8
        reset = 1'b0;
        tick;
        chk("rel1_valid", 32'(disp_valid), 32'd0);
        tick;
        chk("rel2_valid", 32'(disp_valid), 32'd1);
        chk("rel2_data", disp_data, 32'h1234_5678);
        chk("rel2_sel", 32'(sel), 32'd8);
        tick;
        chk("rel3_valid", 32'(disp_valid), 32'd0);
        chk("rel3_busy", 32'(busy), 32'd0);
        exp_sel = 5'd8;

        // Manual wrap in both directions
        exp_sel = model_prev(exp_sel);
        step_manual("prev_wrap", 1'b0, 1'b1, exp_sel);
        exp_sel = model_next(exp_sel);
        step_manual("next_wrap", 1'b1, 1'b0, exp_sel);

        // Both buttons together: no step; the dwell refresh comes 3 idle
        // cycles later (the pulse used the first idle cycle)
        chk("both_idle_before", 32'(busy), 32'd0);
        pulse(1'b1, 1'b1);
        chk("both_busy", 32'(busy), 32'd0);
        chk("both_sel", 32'(sel), 32'(exp_sel));
        wait_capture(1'b0, cs, cd, ch);
        chk("both_cap_sel", 32'(cs), 32'(exp_sel));
        chk("both_cap_holds", 32'(ch), 32'd3);

        // Sink stall: data and valid held, button during SEND dropped
        disp_ready = 1'b0;
        exp_sel = model_next(exp_sel);
        pulse(1'b1, 1'b0);
        chk("stall_sel", 32'(sel), 32'(exp_sel));
        chk("stall_v0", 32'(disp_valid), 32'd0);
        tick;
        chk("stall_v1", 32'(disp_valid), 32'd0);
        tick;
        held = regfile[exp_sel];
        for (int k = 0; k < 10; k++) begin
            chk("stall_valid", 32'(disp_valid), 32'd1);
            chk("stall_data", disp_data, held);
            if (k == 3) regfile[exp_sel] = ~held;
            btn_next = (k == 5);
            tick;
        end
        btn_next = 1'b0;
        disp_ready = 1'b1;
        chk("stall_last_valid", 32'(disp_valid), 32'd1);
        tick;
        chk("stall_done_valid", 32'(disp_valid), 32'd0);
        chk("stall_done_busy", 32'(busy), 32'd0);
        chk("stall_done_sel", 32'(sel), 32'(exp_sel));

        // Manual refresh picks up new register contents
        regfile[exp_sel] = 32'hA;
        wait_capture(1'b0, cs, cd, ch);
        chk("refresh_a_sel", 32'(cs), 32'(exp_sel));
        chk("refresh_a_data", cd, 32'hA);
        chk("refresh_a_holds", 32'(ch), DWELL);
        regfile[exp_sel] = 32'hB;
        wait_capture(1'b0, cs, cd, ch);
        chk("refresh_b_sel", 32'(cs), 32'(exp_sel));
        chk("refresh_b_data", cd, 32'hB);
        chk("refresh_b_holds", 32'(ch), DWELL);

        // Auto scan: two full laps, second with random stalls and buttons
        mode = 1'b1;
        for (int lap = 0; lap < 2; lap++) begin
            for (int i = 0; i < 32; i++) regfile[i] = $urandom;
            for (int c = 0; c < 18; c++) begin
                exp_sel = model_next(exp_sel);
                wait_capture(lap == 1, cs, cd, ch);
                chk("auto_sel", 32'(cs), 32'(exp_sel));
                chk("auto_data", cd, regfile[exp_sel]);
                chk("auto_holds", 32'(ch), DWELL);
            end
        end

        // Back to manual mid-dwell: count continues, refresh same register
        tick; tick;
        mode = 1'b0;
        wait_capture(1'b0, cs, cd, ch);
        chk("mode_sw_sel", 32'(cs), 32'(exp_sel));
        chk("mode_sw_holds", 32'(ch), DWELL - 2);

        // Reset while SEND holds valid, with the sink about to accept
        disp_ready = 1'b0;
        exp_sel = model_next(exp_sel);
        pulse(1'b1, 1'b0);
        tick; tick;
        chk("pre_rst_valid", 32'(disp_valid), 32'd1);
        reset = 1'b1;
        disp_ready = 1'b1;
        tick;
        chk("send_rst_valid", 32'(disp_valid), 32'd0);
        chk("send_rst_sel", 32'(sel), 32'd8);
        chk("send_rst_data", disp_data, 32'd0);
        chk("send_rst_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        wait_capture(1'b0, cs, cd, ch);
        chk("post_rst_sel", 32'(cs), 32'd8);
        chk("post_rst_data", cd, regfile[8]);
        chk("post_rst_holds", 32'(ch), 32'd0);

        // ---------------- report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
